// File: rtl/pwm_dimmer.sv
// 16-step PWM dimmer with a handshaked duty shadow applied at period boundaries.
// Define PWM_FULLSCALE_EN to make duty 15 drive the output high for the full period.
module pwm_dimmer #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] duty,
   input  logic       duty_valid,
   output logic       duty_ready,
   output logic       pwm_out,
   output logic [3:0] duty_active,
   output logic       period_start
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc;
   logic [3:0]    phase;
   logic [3:0]    shadow;
   logic          pending;
   logic          tick;
   logic          boundary;
   logic          xfer;
   logic          full;

   assign tick     = en && (presc == PMAX);
   assign boundary = tick && (phase == 4'd15);
   assign xfer     = duty_valid && !pending;

   assign duty_ready = !pending;

`ifdef PWM_FULLSCALE_EN
   assign full = (duty_active == 4'd15);
`else
   assign full = 1'b0;
`endif

   assign pwm_out = en && (full || (phase < duty_active));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc        <= '0;
         phase        <= '0;
         shadow       <= '0;
         duty_active  <= '0;
         pending      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
         end
         if (tick) begin
            phase <= phase + 4'd1;
         end
         // pending blocks new transfers, so apply and capture never collide
         if (boundary && pending) begin
            duty_active <= shadow;
            pending     <= 1'b0;
         end else if (xfer) begin
            shadow  <= duty;
            pending <= 1'b1;
         end
         period_start <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_dimmer.sv
// Bench for pwm_dimmer: two instances (PRESCALE 1 and 4) share stimulus and are
// checked every cycle against a scoreboard plus hand-derived end-of-segment values.
module tb_pwm_dimmer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       duty_valid = 1'b0;
   logic [3:0] duty = 4'd0;

   logic       rdy1, pwm1, ps1;
   logic [3:0] act1;
   logic       rdy4, pwm4, ps4;
   logic [3:0] act4;

   always #5 clk = ~clk;

   pwm_dimmer #(.PRESCALE(1)) d1 (
      .clk(clk), .reset(reset), .en(en), .duty(duty),
      .duty_valid(duty_valid), .duty_ready(rdy1), .pwm_out(pwm1),
      .duty_active(act1), .period_start(ps1)
   );

   pwm_dimmer #(.PRESCALE(4)) d4 (
      .clk(clk), .reset(reset), .en(en), .duty(duty),
      .duty_valid(duty_valid), .duty_ready(rdy4), .pwm_out(pwm4),
      .duty_active(act4), .period_start(ps4)
   );

   typedef struct {
      int         presc;
      logic [3:0] ph;
      logic [3:0] sh;
      logic [3:0] act;
      logic       pend;
      logic       ps;
   } mst_t;

   typedef struct {
      logic       p1, r1, s1;
      logic [3:0] a1;
      logic       p4, r4, s4;
      logic [3:0] a4;
   } exp_t;

   typedef struct {
      logic       en;
      logic       dv;
      logic [3:0] duty;
      int         n;
      logic [3:0] a1, a4;
      logic       r1, r4, s1, s4;
      int         hi1, hi4;
   } vec_t;

   mst_t m1, m4;
   exp_t exq[$];
   vec_t tbl[5];
   int   npass = 0;
   int   ntot = 0;
   int   cyc = 0;
   int   hi1, hi4;

`ifdef PWM_FULLSCALE_EN
   localparam logic FS = 1'b1;
`else
   localparam logic FS = 1'b0;
`endif

   function automatic mst_t mzero();
      mst_t z;
      z.presc = 0;
      z.ph    = 4'd0;
      z.sh    = 4'd0;
      z.act   = 4'd0;
      z.pend  = 1'b0;
      z.ps    = 1'b0;
      return z;
   endfunction

   function automatic mst_t mstep(mst_t s, int p, logic e, logic v, logic [3:0] d);
      mst_t n;
      logic tk, bd;
      n  = s;
      tk = e && (s.presc == p - 1);
      bd = tk && (s.ph == 4'd15);
      if (e) n.presc = tk ? 0 : s.presc + 1;
      if (tk) n.ph = s.ph + 4'd1;
      if (bd && s.pend) begin
         n.act  = s.sh;
         n.pend = 1'b0;
      end
      if (v && !s.pend) begin
         n.sh   = d;
         n.pend = 1'b1;
      end
      n.ps = bd;
      return n;
   endfunction

   function automatic logic mpwm(mst_t s, logic e);
`ifdef PWM_FULLSCALE_EN
      if (s.act == 4'd15) return e;
`endif
      return e && (s.ph < s.act);
   endfunction

   task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
   endtask

   task automatic cycle(input logic e, input logic v, input logic [3:0] d);
      exp_t x;
      @(negedge clk);
      en = e;
      duty_valid = v;
      duty = d;
      m1 = mstep(m1, 1, e, v, d);
      m4 = mstep(m4, 4, e, v, d);
      x.p1 = mpwm(m1, e);
      x.r1 = !m1.pend;
      x.a1 = m1.act;
      x.s1 = m1.ps;
      x.p4 = mpwm(m4, e);
      x.r4 = !m4.pend;
      x.a4 = m4.act;
      x.s4 = m4.ps;
      exq.push_back(x);
      @(posedge clk);
      #1;
      cyc++;
      x = exq.pop_front();
      chk("sb_pwm1", {7'd0, pwm1}, {7'd0, x.p1});
      chk("sb_rdy1", {7'd0, rdy1}, {7'd0, x.r1});
      chk("sb_act1", {4'd0, act1}, {4'd0, x.a1});
      chk("sb_ps1",  {7'd0, ps1},  {7'd0, x.s1});
      chk("sb_pwm4", {7'd0, pwm4}, {7'd0, x.p4});
      chk("sb_rdy4", {7'd0, rdy4}, {7'd0, x.r4});
      chk("sb_act4", {4'd0, act4}, {4'd0, x.a4});
      chk("sb_ps4",  {7'd0, ps4},  {7'd0, x.s4});
      if (pwm1 === 1'b1) hi1++;
      if (pwm4 === 1'b1) hi4++;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_pwm1"}, {7'd0, pwm1}, 8'd0);
      chk({tag, "_rdy1"}, {7'd0, rdy1}, 8'd1);
      chk({tag, "_act1"}, {4'd0, act1}, 8'd0);
      chk({tag, "_ps1"},  {7'd0, ps1},  8'd0);
      chk({tag, "_pwm4"}, {7'd0, pwm4}, 8'd0);
      chk({tag, "_rdy4"}, {7'd0, rdy4}, 8'd1);
      chk({tag, "_act4"}, {4'd0, act4}, 8'd0);
   endtask

   initial begin
      int h;
      tbl[0] = '{1'b1, 1'b1, 4'd4, 1,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0};
      tbl[1] = '{1'b1, 1'b0, 4'd0, 15, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1,  0};
      tbl[2] = '{1'b1, 1'b0, 4'd0, 48, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 12, 1};
      tbl[3] = '{1'b1, 1'b1, 4'd8, 1,  4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1};
      tbl[4] = '{1'b1, 1'b0, 4'd0, 63, 4'd8, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 27, 15};

      m1 = mzero();
      m4 = mzero();
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("reset");
      reset = 1'b1;

      foreach (tbl[k]) begin
         hi1 = 0;
         hi4 = 0;
         repeat (tbl[k].n) cycle(tbl[k].en, tbl[k].dv, tbl[k].duty);
         chk($sformatf("seg%0d_act1", k), {4'd0, act1}, {4'd0, tbl[k].a1});
         chk($sformatf("seg%0d_act4", k), {4'd0, act4}, {4'd0, tbl[k].a4});
         chk($sformatf("seg%0d_rdy1", k), {7'd0, rdy1}, {7'd0, tbl[k].r1});
         chk($sformatf("seg%0d_rdy4", k), {7'd0, rdy4}, {7'd0, tbl[k].r4});
         chk($sformatf("seg%0d_ps1", k),  {7'd0, ps1},  {7'd0, tbl[k].s1});
         chk($sformatf("seg%0d_ps4", k),  {7'd0, ps4},  {7'd0, tbl[k].s4});
         chk($sformatf("seg%0d_hi1", k),  8'(hi1), 8'(tbl[k].hi1));
         chk($sformatf("seg%0d_hi4", k),  8'(hi4), 8'(tbl[k].hi4));
      end

      // mid-period update at PRESCALE 4 waits for the boundary
      hi4 = 0;
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, cyc == 160, 4'd2);
         if (cyc >= 161 && cyc <= 191) chk("p4_rdy_wait", {7'd0, rdy4}, 8'd0);
         if (cyc == 192) chk("p4_rdy_bnd", {7'd0, rdy4}, 8'd1);
      end
      chk("p4_hi_d8", 8'(hi4), 8'd32);
      hi4 = 0;
      repeat (64) cycle(1'b1, 1'b0, 4'd0);
      chk("p4_hi_d2", 8'(hi4), 8'd8);
      chk("p4_act2", {4'd0, act4}, 8'd2);

      // held valid: 3 taken, 9 ignored until pending clears
      repeat (47) begin
         cycle(1'b1, cyc <= 272, (cyc == 256) ? 4'd3 : 4'd9);
         if (cyc == 257) chk("hold_rdy0", {7'd0, rdy1}, 8'd0);
         if (cyc == 271) chk("hold_act2", {4'd0, act1}, 8'd2);
         if (cyc == 272) chk("hold_act3", {4'd0, act1}, 8'd3);
         if (cyc == 272) chk("hold_rdy1", {7'd0, rdy1}, 8'd1);
         if (cyc == 273) chk("hold_rdy9", {7'd0, rdy1}, 8'd0);
         if (cyc == 287) chk("hold_act3b", {4'd0, act1}, 8'd3);
         if (cyc == 288) chk("hold_act9", {4'd0, act1}, 8'd9);
      end

      // transfer on a boundary cycle
      cycle(1'b1, 1'b1, 4'd6);
      chk("bnd_ps", {7'd0, ps1}, 8'd1);
      chk("bnd_act9", {4'd0, act1}, 8'd9);
      chk("bnd_rdy", {7'd0, rdy1}, 8'd0);
      repeat (16) begin
         cycle(1'b1, 1'b0, 4'd0);
         if (cyc == 319) chk("bnd_hold9", {4'd0, act1}, 8'd9);
         if (cyc == 319) chk("bnd_act4_2", {4'd0, act4}, 8'd2);
      end
      chk("bnd_act6", {4'd0, act1}, 8'd6);
      chk("bnd_act4_3", {4'd0, act4}, 8'd3);

      // freeze at phase 5, handshake still live
      repeat (5) cycle(1'b1, 1'b0, 4'd0);
      chk("frz_pre_pwm", {7'd0, pwm1}, 8'd1);
      repeat (10) begin
         cycle(1'b0, cyc == 329, 4'd11);
         chk("frz_pwm1", {7'd0, pwm1}, 8'd0);
         chk("frz_ps1", {7'd0, ps1}, 8'd0);
         if (cyc == 330) chk("frz_rdy", {7'd0, rdy1}, 8'd0);
      end
      chk("frz_act", {4'd0, act1}, 8'd6);
      repeat (11) begin
         cycle(1'b1, 1'b0, 4'd0);
         if (cyc == 336) chk("res_ps_no", {7'd0, ps1}, 8'd0);
         if (cyc == 345) chk("res_ps_early", {7'd0, ps1}, 8'd0);
      end
      chk("res_ps", {7'd0, ps1}, 8'd1);
      chk("res_act11", {4'd0, act1}, 8'd11);

      // asynchronous reset with a pending value
      repeat (6) cycle(1'b1, cyc == 349, 4'd7);
      chk("ar_pend", {7'd0, rdy1}, 8'd0);
      chk("ar_pwm_pre", {7'd0, pwm1}, 8'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_rst("async");
      m1 = mzero();
      m4 = mzero();
      reset = 1'b1;
      cyc = 0;

      // duty 15 full-scale behaviour
      h = 0;
      cycle(1'b1, 1'b1, 4'd15);
      repeat (30) begin
         cycle(1'b1, 1'b0, 4'd0);
         if (cyc >= 16 && pwm1 === 1'b1) h++;
         if (cyc == 16) chk("fs_act", {4'd0, act1}, 8'd15);
      end
      chk("fs_ph15", {7'd0, pwm1}, {7'd0, FS});
      chk("fs_hi", 8'(h), FS ? 8'd16 : 8'd15);
      chk("sb_empty", 8'(exq.size()), 8'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
